// File: rtl/oam_dma_arbiter.sv
// OAM DMA engine and external-bus arbiter between the CPU pins and the memory bus.
// A write to REG_ADDR starts a LEN-byte copy from {SRC,8'h00} into OAM; while the
// copy runs the engine owns the bus and CPU accesses below 0xFF00 are suppressed.
module oam_dma_arbiter #(
  parameter int unsigned LEN         = 160,
  parameter int unsigned START_DELAY = 1,
  parameter logic [15:0] REG_ADDR    = 16'hFF46
) (
  input  logic        CLK,
  input  logic        SYNC_RESET,
  input  logic [15:0] CPU_A,
  input  logic        CPU_RD,
  input  logic        CPU_WR,
  input  logic [7:0]  CPU_DO,
  output logic [7:0]  CPU_DI,
  output logic        CPU_BLOCKED,
  output logic [15:0] BUS_A,
  output logic        BUS_RD,
  output logic        BUS_WR,
  output logic [7:0]  BUS_DO,
  input  logic [7:0]  BUS_DI,
  output logic [7:0]  OAM_A,
  output logic [7:0]  OAM_D,
  output logic        OAM_WE,
  output logic        DMA_ACTIVE
);

  localparam int unsigned DW = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
  localparam logic [DW-1:0] DelayLast = DW'(START_DELAY - 1);
  localparam logic [7:0]    IdxLast   = 8'(LEN - 1);

  typedef enum logic [1:0] {StIdle, StDelay, StRead, StFlush} state_e;

  state_e          state_q;
  logic [7:0]      src_q;
  logic [7:0]      idx_q;
  logic [DW-1:0]   cnt_q;
  logic            dma_active_q;
  logic            oam_we_q;
  logic [7:0]      oam_a_q;
  logic [7:0]      oam_d_q;

  logic            reg_wr;
  logic            reg_rd;
  logic            cpu_local;
  logic [7:0]      eff_src;

  assign reg_wr    = CPU_WR && (CPU_A == REG_ADDR);
  assign reg_rd    = CPU_RD && (CPU_A == REG_ADDR);
  // FFxx (and the DMA register itself) is serviced on-chip, never on the bus.
  assign cpu_local = (CPU_A[15:8] == 8'hFF) || (CPU_A == REG_ADDR);
  // Echo region 0xE0-0xFF folds back onto 0xC0-0xDF.
  assign eff_src   = (src_q < 8'hE0) ? src_q : (src_q & 8'hDF);

  // Transfer FSM, source register and the one-deep OAM write pipeline.
  always_ff @(posedge CLK) begin
    if (SYNC_RESET) begin
      state_q      <= StIdle;
      src_q        <= 8'h00;
      idx_q        <= 8'h00;
      cnt_q        <= '0;
      dma_active_q <= 1'b0;
      oam_we_q     <= 1'b0;
      oam_a_q      <= 8'h00;
      oam_d_q      <= 8'h00;
    end else begin
      // Runs regardless of the FSM so a captured byte always lands, even on restart.
      oam_we_q <= (state_q == StRead);
      if (state_q == StRead) begin
        oam_a_q <= idx_q;
        oam_d_q <= BUS_DI;
      end

      if (reg_wr) begin
        src_q        <= CPU_DO;
        state_q      <= StDelay;
        cnt_q        <= '0;
        idx_q        <= 8'h00;
        dma_active_q <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
          end
          StDelay: begin
            if (cnt_q == DelayLast) begin
              state_q      <= StRead;
              idx_q        <= 8'h00;
              dma_active_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          StRead: begin
            idx_q <= idx_q + 8'd1;
            if (idx_q == IdxLast) begin
              state_q      <= StFlush;
              dma_active_q <= 1'b0;
            end
          end
          StFlush: begin
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

  // Bus ownership and the CPU-facing view of the current access.
  always_comb begin
    BUS_A       = CPU_A;
    BUS_RD      = 1'b0;
    BUS_WR      = 1'b0;
    BUS_DO      = CPU_DO;
    CPU_DI      = 8'hFF;
    CPU_BLOCKED = 1'b0;
    if (dma_active_q) begin
      BUS_A       = {eff_src, idx_q};
      BUS_RD      = 1'b1;
      BUS_DO      = 8'h00;
      CPU_BLOCKED = !cpu_local && (CPU_RD || CPU_WR);
    end else if (!cpu_local) begin
      BUS_RD = CPU_RD;
      BUS_WR = CPU_WR;
      CPU_DI = BUS_DI;
    end
    if (reg_rd) begin
      CPU_DI = src_q;
    end
  end

  assign OAM_WE     = oam_we_q;
  assign OAM_A      = oam_a_q;
  assign OAM_D      = oam_d_q;
  assign DMA_ACTIVE = dma_active_q;

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Scoreboard bench for oam_dma_arbiter: the stimulus process keeps a timeline model
// (source byte, active window, queue of expected OAM writes) and a monitor on the
// falling edge compares the DUT's bus/CPU/OAM outputs against it.
module tb_oam_dma_arbiter;

  localparam int unsigned LEN         = 160;
  localparam int unsigned START_DELAY = 1;
  localparam logic [15:0] REG_ADDR    = 16'hFF46;

  logic        clk;
  logic        sync_reset;
  logic [15:0] cpu_a;
  logic        cpu_rd;
  logic        cpu_wr;
  logic [7:0]  cpu_do;
  logic [7:0]  cpu_di;
  logic        cpu_blocked;
  logic [15:0] bus_a;
  logic        bus_rd;
  logic        bus_wr;
  logic [7:0]  bus_do;
  logic [7:0]  bus_di;
  logic [7:0]  oam_a;
  logic [7:0]  oam_d;
  logic        oam_we;
  logic        dma_active;

  oam_dma_arbiter #(
    .LEN        (LEN),
    .START_DELAY(START_DELAY),
    .REG_ADDR   (REG_ADDR)
  ) dut (
    .CLK        (clk),
    .SYNC_RESET (sync_reset),
    .CPU_A      (cpu_a),
    .CPU_RD     (cpu_rd),
    .CPU_WR     (cpu_wr),
    .CPU_DO     (cpu_do),
    .CPU_DI     (cpu_di),
    .CPU_BLOCKED(cpu_blocked),
    .BUS_A      (bus_a),
    .BUS_RD     (bus_rd),
    .BUS_WR     (bus_wr),
    .BUS_DO     (bus_do),
    .BUS_DI     (bus_di),
    .OAM_A      (oam_a),
    .OAM_D      (oam_d),
    .OAM_WE     (oam_we),
    .DMA_ACTIVE (dma_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents seen on the external bus.
  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h5A;
  endfunction

  function automatic logic [7:0] eff_of(input logic [7:0] s);
    return (s >= 8'hE0) ? s - 8'h20 : s;
  endfunction

  assign bus_di = mem_byte(bus_a);

  typedef struct {
    int         cyc;
    logic [7:0] a;
    logic [7:0] d;
  } oam_t;

  // Model state; cyc counts rising edges, window = cycles the DMA owns the bus.
  oam_t       exp_q[$];
  int         cyc = 0;
  logic [7:0] src_m = 8'h00;
  bit         win_on = 1'b0;
  int         win_start = 0;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, got, want);
    end
  endtask

  // Apply the rules of one rising edge to the model, using the inputs present at it.
  task automatic model_edge();
    cyc++;
    if (sync_reset) begin
      exp_q.delete();
      win_on = 1'b0;
      src_m  = 8'h00;
    end else if (cpu_wr && cpu_a == REG_ADDR) begin
      src_m = cpu_do;
      // Anything already captured lands at this cycle; later bytes are cancelled.
      while (exp_q.size() > 0 && exp_q[$].cyc > cyc) void'(exp_q.pop_back());
      win_on    = 1'b1;
      win_start = cyc + START_DELAY;
      for (int i = 0; i < LEN; i++) begin
        oam_t e;
        e.cyc = win_start + 1 + i;
        e.a   = 8'(i);
        e.d   = mem_byte({eff_of(cpu_do), 8'(i)});
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_in();
    cpu_a  = 16'h0000;
    cpu_rd = 1'b0;
    cpu_wr = 1'b0;
    cpu_do = 8'h00;
  endtask

  task automatic drive(input logic [15:0] a, input logic rd, input logic wr, input logic [7:0] d);
    cpu_a  = a;
    cpu_rd = rd;
    cpu_wr = wr;
    cpu_do = d;
  endtask

  // Random CPU traffic that never writes the DMA register.
  task automatic rand_traffic();
    logic [15:0] a;
    int          op;
    case ($urandom_range(0, 5))
      0:       a = 16'h8000;
      1:       a = 16'hC123;
      2:       a = 16'hFF80;
      3:       a = REG_ADDR;
      4:       a = {8'hFF, 8'($urandom)};
      default: a = 16'($urandom);
    endcase
    op = $urandom_range(0, 3);
    if (op == 2 && a == REG_ADDR) a = 16'hFF47;
    drive(a, op == 1 || op == 3, op == 2, 8'($urandom));
  endtask

  // Monitor: compare outputs mid-cycle against the model.
  initial begin
    forever begin
      int         c;
      bit         act;
      bit         loc;
      logic [7:0] idx_e;
      @(negedge clk);
      c     = cyc;
      act   = win_on && c >= win_start && c < win_start + int'(LEN);
      loc   = (cpu_a[15:8] == 8'hFF);
      idx_e = 8'(c - win_start);
      chk("dma_active", 16'(dma_active), 16'(act));
      if (act) begin
        chk("dma_bus_rd", 16'(bus_rd), 16'd1);
        chk("dma_bus_wr", 16'(bus_wr), 16'd0);
        chk("dma_bus_a", bus_a, {eff_of(src_m), idx_e});
        chk("dma_blocked", 16'(cpu_blocked), 16'(!loc && (cpu_rd || cpu_wr)));
        if (cpu_rd && !loc) chk("blocked_rd_di", 16'(cpu_di), 16'h00FF);
      end else if (!loc) begin
        chk("pass_bus_a", bus_a, cpu_a);
        chk("pass_bus_rd", 16'(bus_rd), 16'(cpu_rd));
        chk("pass_bus_wr", 16'(bus_wr), 16'(cpu_wr));
        if (cpu_wr) chk("pass_bus_do", 16'(bus_do), 16'(cpu_do));
        chk("pass_blocked", 16'(cpu_blocked), 16'd0);
        if (cpu_rd) chk("pass_cpu_di", 16'(cpu_di), 16'(mem_byte(cpu_a)));
      end else begin
        chk("ff_bus_rd", 16'(bus_rd), 16'd0);
        chk("ff_bus_wr", 16'(bus_wr), 16'd0);
        chk("ff_blocked", 16'(cpu_blocked), 16'd0);
      end
      if (cpu_rd && loc) begin
        chk("ff_cpu_di", 16'(cpu_di), (cpu_a == REG_ADDR) ? 16'(src_m) : 16'h00FF);
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == c) begin
        oam_t e;
        e = exp_q.pop_front();
        chk("oam_we", 16'(oam_we), 16'd1);
        chk("oam_a", 16'(oam_a), 16'(e.a));
        chk("oam_d", 16'(oam_d), 16'(e.d));
      end else begin
        chk("oam_we_idle", 16'(oam_we), 16'd0);
      end
    end
  end

  // Stimulus.
  initial begin
    sync_reset = 1'b1;
    idle_in();
    repeat (3) tick();
    sync_reset = 1'b0;
    tick();

    // Idle pass-through write and register reset value.
    drive(16'hA000, 1'b0, 1'b1, 8'h5A);
    tick();
    drive(REG_ADDR, 1'b1, 1'b0, 8'h00);
    tick();

    // Basic copy from 0xC000 with CPU traffic (0x8000 / 0xC123 / 0xFF80 ...) alongside.
    drive(REG_ADDR, 1'b0, 1'b1, 8'hC0);
    tick();
    for (int i = 0; i < LEN + 10; i++) begin
      rand_traffic();
      tick();
    end

    // Folded source and readback.
    drive(REG_ADDR, 1'b0, 1'b1, 8'hE5);
    tick();
    drive(REG_ADDR, 1'b1, 1'b0, 8'h00);
    tick();
    for (int i = 0; i < LEN + 10; i++) begin
      rand_traffic();
      tick();
    end

    // Restart while reading idx 50.
    drive(REG_ADDR, 1'b0, 1'b1, 8'hC0);
    tick();
    idle_in();
    repeat (START_DELAY + 50) tick();
    drive(REG_ADDR, 1'b0, 1'b1, 8'h80);
    tick();
    for (int i = 0; i < LEN + 10; i++) begin
      rand_traffic();
      tick();
    end

    // Reset at idx 10 together with a register write.
    drive(REG_ADDR, 1'b0, 1'b1, 8'hD3);
    tick();
    idle_in();
    repeat (START_DELAY + 10) tick();
    sync_reset = 1'b1;
    drive(REG_ADDR, 1'b0, 1'b1, 8'h77);
    tick();
    sync_reset = 1'b0;
    drive(REG_ADDR, 1'b1, 1'b0, 8'h00);
    tick();
    for (int i = 0; i < 20; i++) begin
      rand_traffic();
      tick();
    end

    // Randomized soak with occasional restarts and resets.
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 999);
      sync_reset = (r == 0);
      if (r >= 1 && r <= 3) drive(REG_ADDR, 1'b0, 1'b1, 8'($urandom));
      else rand_traffic();
      tick();
    end
    sync_reset = 1'b0;
    idle_in();
    repeat (LEN + 10) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
